// File: rtl/cmd_saver.sv
// ============================================================================
// cmd_saver : streams a RAM range out as a TRS-80 /CMD file over ioctl upload
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cmd_saver #(
  parameter int INDEX       = 2,
  parameter int BLOCK       = 256,
  parameter int RAM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [15:0] entry_addr,
  input  logic        ioctl_upload,
  input  logic [15:0] ioctl_index,
  input  logic        ioctl_rd,
  input  logic [23:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [15:0] saver_addr,
  output logic        saver_rd,
  input  logic [7:0]  saver_din,
  output logic        saver_upload,
  output logic [23:0] file_size,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HDR_TYPE = 4'd1,
    S_HDR_LEN  = 4'd2,
    S_HDR_LSB  = 4'd3,
    S_HDR_MSB  = 4'd4,
    S_FETCH    = 4'd5,
    S_DATA     = 4'd6,
    S_TRL_TYPE = 4'd7,
    S_TRL_LEN  = 4'd8,
    S_TRL_LSB  = 4'd9,
    S_TRL_MSB  = 4'd10,
    S_DONE     = 4'd11
  } state_t;

  state_t      state_q;
  logic [15:0] cur_q;
  logic [15:0] entry_q;
  logic [16:0] rem_q;
  logic [8:0]  blk_q;
  logic [7:0]  lat_q;
  logic [7:0]  din_q;
  logic        wait_q;
  logic [15:0] addr_q;
  logic        rd_q;
  logic        upload_q;
  logic [23:0] fsize_q;
  logic        error_q;

  logic        w_start;
  logic        w_err;
  logic [16:0] w_span;
  logic [16:0] w_nblk;
  logic [23:0] w_fsize;
  logic [8:0]  w_n;
  logic [7:0]  w_len;
  logic [15:0] cur_d;
  logic [16:0] rem_d;
  logic [8:0]  blk_d;

  assign w_start = ioctl_upload && (ioctl_index == 16'(INDEX)) && (ioctl_addr == 24'd0);
  assign w_err   = end_addr < start_addr;
  assign w_span  = {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
  assign w_nblk  = (w_span + 17'(BLOCK - 1)) / 17'(BLOCK);
  assign w_fsize = w_err ? 24'd4 : ({7'd0, w_span} + {5'd0, w_nblk, 2'b00} + 24'd4);

  // Block size for the header about to be emitted; a 256-byte block encodes as length 02.
  assign w_n   = (rem_q >= 17'(BLOCK)) ? 9'(BLOCK) : rem_q[8:0];
  assign w_len = w_n[7:0] + 8'd2;

  assign cur_d = cur_q + 16'd1;
  assign rem_d = rem_q - 17'd1;
  assign blk_d = blk_q - 9'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cur_q    <= 16'd0;
      entry_q  <= 16'd0;
      rem_q    <= 17'd0;
      blk_q    <= 9'd0;
      lat_q    <= 8'd0;
      din_q    <= 8'd0;
      wait_q   <= 1'b0;
      addr_q   <= 16'd0;
      rd_q     <= 1'b0;
      upload_q <= 1'b0;
      fsize_q  <= 24'd0;
      error_q  <= 1'b0;
    end else if (state_q != S_IDLE && !ioctl_upload) begin
      // Consumer gave up (or finished): release the RAM mux, keep last byte and size visible.
      state_q  <= S_IDLE;
      upload_q <= 1'b0;
      rd_q     <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            cur_q    <= start_addr;
            entry_q  <= entry_addr;
            rem_q    <= w_err ? 17'd0 : w_span;
            error_q  <= w_err;
            fsize_q  <= w_fsize;
            upload_q <= 1'b1;
            wait_q   <= 1'b0;
            if (w_err) begin
              din_q   <= 8'h02;
              state_q <= S_TRL_TYPE;
            end else begin
              din_q   <= 8'h01;
              state_q <= S_HDR_TYPE;
            end
          end
        end
        S_HDR_TYPE: if (ioctl_rd) begin
          din_q   <= w_len;
          blk_q   <= w_n;
          state_q <= S_HDR_LEN;
        end
        S_HDR_LEN: if (ioctl_rd) begin
          din_q   <= cur_q[7:0];
          state_q <= S_HDR_LSB;
        end
        S_HDR_LSB: if (ioctl_rd) begin
          din_q   <= cur_q[15:8];
          state_q <= S_HDR_MSB;
        end
        S_HDR_MSB: if (ioctl_rd) begin
          wait_q  <= 1'b1;
          addr_q  <= cur_q;
          rd_q    <= 1'b1;
          lat_q   <= 8'd0;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (lat_q == 8'(RAM_LATENCY - 1)) begin
            din_q   <= saver_din;
            wait_q  <= 1'b0;
            rd_q    <= 1'b0;
            state_q <= S_DATA;
          end else begin
            lat_q <= lat_q + 8'd1;
          end
        end
        S_DATA: if (ioctl_rd) begin
          cur_q <= cur_d;
          rem_q <= rem_d;
          blk_q <= blk_d;
          if (blk_d != 9'd0) begin
            wait_q  <= 1'b1;
            addr_q  <= cur_d;
            rd_q    <= 1'b1;
            lat_q   <= 8'd0;
            state_q <= S_FETCH;
          end else if (rem_d != 17'd0) begin
            din_q   <= 8'h01;
            state_q <= S_HDR_TYPE;
          end else begin
            din_q   <= 8'h02;
            state_q <= S_TRL_TYPE;
          end
        end
        S_TRL_TYPE: if (ioctl_rd) begin
          din_q   <= 8'h02;
          state_q <= S_TRL_LEN;
        end
        S_TRL_LEN: if (ioctl_rd) begin
          din_q   <= entry_q[7:0];
          state_q <= S_TRL_LSB;
        end
        S_TRL_LSB: if (ioctl_rd) begin
          din_q   <= entry_q[15:8];
          state_q <= S_TRL_MSB;
        end
        S_TRL_MSB: if (ioctl_rd) begin
          din_q   <= 8'h00;
          state_q <= S_DONE;
        end
        S_DONE: begin
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ioctl_din    = din_q;
  assign ioctl_wait   = wait_q;
  assign saver_addr   = addr_q;
  assign saver_rd     = rd_q;
  assign saver_upload = upload_q;
  assign file_size    = fsize_q;
  assign error        = error_q;

endmodule

`default_nettype wire

// File: doc/cmd_saver.md
Name: cmd_saver

Overview:
- Serialises a TRS-80 RAM range into a /CMD file stream for MiSTer ioctl upload ("save"); the reverse of the CMD download/load path.
- Reads emulator RAM through a dedicated read port, splits the range into type-01 load blocks, then appends a type-02 transfer (entry) block.
- The emitted stream reloads byte-exact through the core's CMD loader.

Parameters:
INDEX, 2, ioctl_index[5:0] value that selects this saver (ioctl_index[15:6] must be 0).
BLOCK, 256, maximum data bytes per type-01 block (legal range 1..256).
RAM_LATENCY, 2, clocks from a saver_addr change to valid saver_din (≥1).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_addr  in  16  first RAM byte to save; sampled at upload start
end_addr  in  16  last RAM byte to save, inclusive; sampled at upload start
entry_addr  in  16  execute address written to the type-02 block; sampled at upload start
ioctl_upload  in  1  upload active
ioctl_index  in  16  menu index
ioctl_rd  in  1  1-clock pulse: consumer has taken the current ioctl_din byte
ioctl_addr  in  24  file offset of the current byte (0 at start)
ioctl_din  out  8  current file byte (registered)
ioctl_wait  out  1  high = ioctl_din not yet valid; consumer holds
saver_addr  out  16  RAM read address
saver_rd  out  1  RAM read strobe
saver_din  in  8  RAM read data
saver_upload  out  1  saver busy (drives the RAM mux)
file_size  out  24  total stream length in bytes; valid from the first clock of BUSY
error  out  1  end_addr < start_addr at upload start

Behaviour:
- Reset values: ioctl_din=00, ioctl_wait=0, saver_addr=0000, saver_rd=0, saver_upload=0, file_size=0, error=0, state=IDLE.
- Start condition (IDLE only): ioctl_upload=1, index matches, ioctl_addr=0.
  - On start, latch cur=start_addr and rem=end_addr-start_addr+1 (17-bit, 1..65536).
  - Set saver_upload=1 and error=(end_addr<start_addr); error stays until the next start or reset.
  - file_size = N + 4*ceil(N/BLOCK) + 4, where N=rem; if error, N=0 and file_size=4.
  - Go to HDR_TYPE, or TRL_TYPE if error.
- Stream format:
  - Per block, n = min(rem, BLOCK): bytes 01, (n+2) mod 256, cur[7:0], cur[15:8], then n data bytes RAM[cur..cur+n-1].
  - Trailer: 02, 02, entry[7:0], entry[15:8].
- Handshake:
  - The consumer samples ioctl_din only while ioctl_wait=0, and leaves ≥1 idle clock between ioctl_rd pulses.
  - ioctl_rd while ioctl_wait=1 is ignored.
  - The saver never depends on ioctl_addr after start; it counts consumed bytes internally.
- States:
  - HDR_TYPE, HDR_LEN, HDR_LSB, HDR_MSB: ioctl_din holds the header byte, ioctl_wait=0. On ioctl_rd, load the next byte on the following edge and advance.
  - HDR_MSB + ioctl_rd -> FETCH.
  - FETCH: on entry, ioctl_wait=1, saver_addr=cur, saver_rd=1. Count RAM_LATENCY clocks, then latch saver_din into ioctl_din, set ioctl_wait=0 and saver_rd=0, go to DATA.
  - DATA + ioctl_rd: cur+=1, rem-=1, block count-=1.
    - Block count still >0 -> FETCH.
    - Block count 0 and rem>0 -> HDR_TYPE.
    - rem=0 -> TRL_TYPE.
  - TRL_TYPE, TRL_LEN, TRL_LSB, TRL_MSB: same handshake as the header states. TRL_MSB + ioctl_rd -> DONE.
  - DONE: ioctl_din=00, ioctl_wait=0, extra ioctl_rd ignored. When ioctl_upload falls -> IDLE, saver_upload=0.
- Address arithmetic: cur is 16-bit. An inclusive range ending at FFFF completes without reading past FFFF; the increment after the last byte is unused.
- Abort: ioctl_upload falling in any non-IDLE state -> IDLE next clock. saver_upload, saver_rd and ioctl_wait clear; ioctl_din and file_size keep their values.
- start_addr, end_addr and entry_addr changes during BUSY have no effect.
- Reset mid-operation forces all reset values immediately.

Test Plan:
- start=5200, end=5202, entry=5200, RAM=D0 D1 D2 -> stream 01 05 00 52 D0 D1 D2 02 02 00 52; file_size=11; error=0.
- Range 6000..60FF (256 bytes) -> single block with length byte 02; file_size=264; trailer follows the byte at 60FF.
- Range 6000..6100 (257 bytes) -> blocks "01 02 00 60 …" then "01 03 00 61 xx"; file_size=269.
- start=7000, end=6FFF, entry=1234 -> error=1; stream 02 02 34 12; file_size=4; no saver_rd pulses.
- Randomised ioctl_rd gaps (1..20 clocks) with RAM_LATENCY=3 -> ioctl_wait high exactly 3 clocks per data byte; bytes match a RAM model; the stream round-trips through the CMD loader to identical RAM contents.
- Drop ioctl_upload after 7 bytes -> IDLE next clock, saver_upload=0. A new upload restarts at byte 01; a wrong-index upload (index 3) is ignored.
